cpu_core: RTL and testbench

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_core.sv | 184 ++++++++++++++++++
 tb/tb_cpu_core.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// Unpipelined RV32I-subset core. Each instruction takes a FETCH and an EXEC cycle.
// The core halts after executing the instruction at word index last_pc.
module cpu_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_data,
  input  logic [31:0] last_pc,
  output logic [31:0] instr_addr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we
);
  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2} state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_e      state_r, state_next_s;
  logic [31:0] pc_r, pc_next_s;
  logic [31:0] regs_r [32];

  logic [6:0]  opcode_s, funct7_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s, imm_u_s;
  logic [31:0] rs1_val_s, rs2_val_s;
  logic        rd_we_s, is_sw_s, taken_s, exec_s, at_last_s;
  logic [31:0] rd_wdata_s;

  assign opcode_s = instr_data[6:0];
  assign rd_s     = instr_data[11:7];
  assign funct3_s = instr_data[14:12];
  assign rs1_s    = instr_data[19:15];
  assign rs2_s    = instr_data[24:20];
  assign funct7_s = instr_data[31:25];

  assign imm_i_s = {{20{instr_data[31]}}, instr_data[31:20]};
  assign imm_s_s = {{20{instr_data[31]}}, instr_data[31:25], instr_data[11:7]};
  assign imm_b_s = {{19{instr_data[31]}}, instr_data[31], instr_data[7],
                    instr_data[30:25], instr_data[11:8], 1'b0};
  assign imm_j_s = {{11{instr_data[31]}}, instr_data[31], instr_data[19:12],
                    instr_data[20], instr_data[30:21], 1'b0};
  assign imm_u_s = {instr_data[31:12], 12'h000};

  assign rs1_val_s = (rs1_s == 5'd0) ? 32'd0 : regs_r[rs1_s];
  assign rs2_val_s = (rs2_s == 5'd0) ? 32'd0 : regs_r[rs2_s];

  assign exec_s    = (state_r == EXEC);
  assign at_last_s = ({2'b00, pc_r[31:2]} == last_pc);

  assign instr_addr = pc_r;
  assign mem_we     = exec_s & is_sw_s & ~rst;
  assign mem_addr   = rs1_val_s + imm_s_s;
  assign mem_data   = rs2_val_s;

  // Instruction decode, ALU, branch resolution and next-PC selection
  always_comb begin
    pc_next_s  = pc_r + 32'd4;
    rd_we_s    = 1'b0;
    rd_wdata_s = 32'd0;
    is_sw_s    = 1'b0;
    taken_s    = 1'b0;
    case (opcode_s)
      OPC_LUI: begin
        rd_we_s    = 1'b1;
        rd_wdata_s = imm_u_s;
      end
      OPC_OPIMM: begin
        rd_we_s = 1'b1;
        case (funct3_s)
          3'b000:  rd_wdata_s = rs1_val_s + imm_i_s;
          3'b111:  rd_wdata_s = rs1_val_s & imm_i_s;
          3'b110:  rd_wdata_s = rs1_val_s | imm_i_s;
          3'b100:  rd_wdata_s = rs1_val_s ^ imm_i_s;
          3'b010:  rd_wdata_s = {31'd0, $signed(rs1_val_s) < $signed(imm_i_s)};
          default: rd_we_s    = 1'b0;
        endcase
      end
      OPC_OP: begin
        rd_we_s = 1'b1;
        case ({funct7_s, funct3_s})
          10'b0000000_000: rd_wdata_s = rs1_val_s + rs2_val_s;
          10'b0100000_000: rd_wdata_s = rs1_val_s - rs2_val_s;
          10'b0000000_111: rd_wdata_s = rs1_val_s & rs2_val_s;
          10'b0000000_110: rd_wdata_s = rs1_val_s | rs2_val_s;
          10'b0000000_100: rd_wdata_s = rs1_val_s ^ rs2_val_s;
          10'b0000000_001: rd_wdata_s = rs1_val_s << rs2_val_s[4:0];
          10'b0000000_101: rd_wdata_s = rs1_val_s >> rs2_val_s[4:0];
          10'b0100000_101: rd_wdata_s = $signed(rs1_val_s) >>> rs2_val_s[4:0];
          10'b0000000_010: rd_wdata_s = {31'd0, $signed(rs1_val_s) < $signed(rs2_val_s)};
          default:         rd_we_s    = 1'b0;
        endcase
      end
      OPC_STORE: begin
        if (funct3_s == 3'b010) begin
          is_sw_s = 1'b1;
        end else begin
          is_sw_s = 1'b0;
        end
      end
      OPC_BRANCH: begin
        case (funct3_s)
          3'b000:  taken_s = (rs1_val_s == rs2_val_s);
          3'b001:  taken_s = (rs1_val_s != rs2_val_s);
          3'b100:  taken_s = ($signed(rs1_val_s) <  $signed(rs2_val_s));
          3'b101:  taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
          default: taken_s = 1'b0;
        endcase
        if (taken_s) begin
          pc_next_s = (pc_r + imm_b_s) & ALIGN_MASK;
        end else begin
          pc_next_s = pc_r + 32'd4;
        end
      end
      OPC_JAL: begin
        rd_we_s    = 1'b1;
        rd_wdata_s = pc_r + 32'd4;
        pc_next_s  = (pc_r + imm_j_s) & ALIGN_MASK;
      end
      OPC_JALR: begin
        if (funct3_s == 3'b000) begin
          rd_we_s    = 1'b1;
          rd_wdata_s = pc_r + 32'd4;
          pc_next_s  = (rs1_val_s + imm_i_s) & ALIGN_MASK;
        end else begin
          rd_we_s    = 1'b0;
        end
      end
      default: rd_we_s = 1'b0;
    endcase
  end

  // Sequencer next state; HALT is left only through reset
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH: state_next_s = EXEC;
      EXEC: begin
        if (at_last_s) begin
          state_next_s = HALT;
        end else begin
          state_next_s = FETCH;
        end
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = FETCH;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Program counter, advanced once per executed instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= 32'd0;
    end else if (exec_s) begin
      pc_r <= pc_next_s;
    end
  end

  // Register file; writes to x0 are dropped so it always reads zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (exec_s && rd_we_s && (rd_s != 5'd0)) begin
      regs_r[rd_s] <= rd_wdata_s;
    end
  end
endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: reset vector table, directed program sequences and random
// forward-flowing programs checked against an instruction-level reference model.
module tb_cpu_core;
  typedef enum logic [4:0] {
    OP_LUI, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI,
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT,
    OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JAL, OP_JALR, OP_BAD
  } op_e;

  typedef struct {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } ins_t;

  typedef struct {
    logic        rst;
    logic [31:0] addr;
    logic        we;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_data = 32'd0;
  logic [31:0] last_pc = 32'd100;
  logic [31:0] instr_addr, mem_addr, mem_data;
  logic        mem_we;

  logic [31:0] rom [64];
  ins_t        prog [64];
  logic [31:0] exp_addr [$], exp_data [$], act_addr [$], act_data [$];
  int          checks = 0;
  int          failures = 0;

  cpu_core dut (
    .clk(clk), .rst(rst), .instr_data(instr_data), .last_pc(last_pc),
    .instr_addr(instr_addr), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  // synchronous instruction ROM
  always @(posedge clk) instr_data <= rom[instr_addr[7:2]];

  // store capture
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      act_addr.push_back(mem_addr);
      act_data.push_back(mem_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] sext12(input logic [31:0] v);
    return {{20{v[11]}}, v[11:0]};
  endfunction

  function automatic logic [31:0] enc(input ins_t c);
    logic [31:0] m;
    m = c.imm;
    case (c.op)
      OP_LUI:  return {m[31:12], c.rd, 7'b0110111};
      OP_ADDI: return {m[11:0], c.rs1, 3'b000, c.rd, 7'b0010011};
      OP_ANDI: return {m[11:0], c.rs1, 3'b111, c.rd, 7'b0010011};
      OP_ORI:  return {m[11:0], c.rs1, 3'b110, c.rd, 7'b0010011};
      OP_XORI: return {m[11:0], c.rs1, 3'b100, c.rd, 7'b0010011};
      OP_SLTI: return {m[11:0], c.rs1, 3'b010, c.rd, 7'b0010011};
      OP_ADD:  return {7'b0000000, c.rs2, c.rs1, 3'b000, c.rd, 7'b0110011};
      OP_SUB:  return {7'b0100000, c.rs2, c.rs1, 3'b000, c.rd, 7'b0110011};
      OP_AND:  return {7'b0000000, c.rs2, c.rs1, 3'b111, c.rd, 7'b0110011};
      OP_OR:   return {7'b0000000, c.rs2, c.rs1, 3'b110, c.rd, 7'b0110011};
      OP_XOR:  return {7'b0000000, c.rs2, c.rs1, 3'b100, c.rd, 7'b0110011};
      OP_SLL:  return {7'b0000000, c.rs2, c.rs1, 3'b001, c.rd, 7'b0110011};
      OP_SRL:  return {7'b0000000, c.rs2, c.rs1, 3'b101, c.rd, 7'b0110011};
      OP_SRA:  return {7'b0100000, c.rs2, c.rs1, 3'b101, c.rd, 7'b0110011};
      OP_SLT:  return {7'b0000000, c.rs2, c.rs1, 3'b010, c.rd, 7'b0110011};
      OP_SW:   return {m[11:5], c.rs2, c.rs1, 3'b010, m[4:0], 7'b0100011};
      OP_BEQ:  return {m[12], m[10:5], c.rs2, c.rs1, 3'b000, m[4:1], m[11], 7'b1100011};
      OP_BNE:  return {m[12], m[10:5], c.rs2, c.rs1, 3'b001, m[4:1], m[11], 7'b1100011};
      OP_BLT:  return {m[12], m[10:5], c.rs2, c.rs1, 3'b100, m[4:1], m[11], 7'b1100011};
      OP_BGE:  return {m[12], m[10:5], c.rs2, c.rs1, 3'b101, m[4:1], m[11], 7'b1100011};
      OP_JAL:  return {m[20], m[10:1], m[11], m[19:12], c.rd, 7'b1101111};
      OP_JALR: return {m[11:0], c.rs1, 3'b000, c.rd, 7'b1100111};
      default: begin
        // encodings outside the supported subset (SLLI, MUL, SB, branch f3=010, LW)
        if (m[2:0] == 3'd0)      return {7'b0000000, 5'd1, c.rs1, 3'b001, c.rd, 7'b0010011};
        else if (m[2:0] == 3'd1) return {7'b0000001, c.rs2, c.rs1, 3'b000, c.rd, 7'b0110011};
        else if (m[2:0] == 3'd2) return {7'b0000000, c.rs2, c.rs1, 3'b000, 5'd0, 7'b0100011};
        else if (m[2:0] == 3'd3) return {7'b0000000, c.rs2, c.rs1, 3'b010, 5'd8, 7'b1100011};
        else                     return {12'd0, c.rs1, 3'b010, c.rd, 7'b0000011};
      end
    endcase
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) begin
      prog[i] = '{op: OP_ADDI, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0};
      rom[i]  = enc(prog[i]);
    end
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic put(input int w, input op_e op, input int rd, input int rs1, input int rs2,
                     input logic [31:0] imm);
    prog[w] = '{op: op, rd: 5'(rd), rs1: 5'(rs1), rs2: 5'(rs2), imm: imm};
    rom[w]  = enc(prog[w]);
  endtask

  task automatic expect_store(input logic [31:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  // Two reset cycles; returns at the mid-point of the first FETCH cycle (cycle 1).
  task automatic start(input logic [31:0] lp);
    last_pc = lp;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    act_addr.delete();
    act_data.delete();
  endtask

  task automatic finish_run(input string tag, input int cycles, input logic [31:0] final_pc);
    repeat (cycles) @(negedge clk);
    chk({tag, "_store_count"}, 32'(act_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < act_addr.size()) begin
        chk($sformatf("%s_store%0d_addr", tag, i), act_addr[i], exp_addr[i]);
        chk($sformatf("%s_store%0d_data", tag, i), act_data[i], exp_data[i]);
      end
    end
    chk({tag, "_halt_pc"}, instr_addr, final_pc);
  endtask

  // Instruction-level reference: executes prog[] until the last_pc word has run.
  task automatic run_model(input logic [31:0] lp, output logic [31:0] fpc, output int steps);
    logic [31:0] r [32];
    logic [31:0] pc, a, b, nx, val;
    logic        wr;
    ins_t        c;
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    pc = 32'd0; steps = 0; fpc = 32'd0;
    exp_addr.delete();
    exp_data.delete();
    while (steps < 2000) begin
      c = prog[pc[7:2]];
      a = r[c.rs1]; b = r[c.rs2]; nx = pc + 32'd4; wr = 1'b1; val = 32'd0;
      case (c.op)
        OP_LUI:  val = c.imm;
        OP_ADDI: val = a + c.imm;
        OP_ANDI: val = a & c.imm;
        OP_ORI:  val = a | c.imm;
        OP_XORI: val = a ^ c.imm;
        OP_SLTI: val = ($signed(a) < $signed(c.imm)) ? 32'd1 : 32'd0;
        OP_ADD:  val = a + b;
        OP_SUB:  val = a - b;
        OP_AND:  val = a & b;
        OP_OR:   val = a | b;
        OP_XOR:  val = a ^ b;
        OP_SLL:  val = a << b[4:0];
        OP_SRL:  val = a >> b[4:0];
        OP_SRA:  val = $signed(a) >>> b[4:0];
        OP_SLT:  val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        OP_JAL:  begin val = pc + 32'd4; nx = (pc + c.imm) & 32'hFFFF_FFFC; end
        OP_JALR: begin val = pc + 32'd4; nx = (a + c.imm) & 32'hFFFF_FFFC; end
        default: begin
          wr = 1'b0;
          if (c.op == OP_SW) expect_store(a + c.imm, b);
          if ((c.op == OP_BEQ && a == b) || (c.op == OP_BNE && a != b) ||
              (c.op == OP_BLT && $signed(a) < $signed(b)) ||
              (c.op == OP_BGE && $signed(a) >= $signed(b)))
            nx = (pc + c.imm) & 32'hFFFF_FFFC;
        end
      endcase
      if (wr && c.rd != 5'd0) r[c.rd] = val;
      steps++;
      if ({2'b00, pc[31:2]} == lp) begin
        fpc = nx;
        break;
      end
      pc = nx;
    end
  endtask

  // Random program whose control flow only moves forward, so it always reaches its last word.
  task automatic gen_prog(input int len);
    clear_rom();
    for (int i = 0; i < len; i++) begin
      ins_t        n;
      int          t;
      logic [31:0] rv;
      rv    = $urandom();
      n.op  = op_e'($urandom_range(0, 22));
      n.rd  = 5'($urandom_range(0, 7));
      n.rs1 = 5'($urandom_range(0, 7));
      n.rs2 = 5'($urandom_range(0, 7));
      n.imm = sext12(rv);
      if (n.op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JAL, OP_JALR} && i == len - 1)
        n.op = OP_ADDI;
      t = $urandom_range(i + 1, len - 1);
      if (n.op == OP_LUI) n.imm = {rv[31:12], 12'h000};
      if (n.op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JAL}) n.imm = 32'((t - i) * 4);
      if (n.op == OP_JALR) begin
        n.rs1 = 5'd0;
        n.imm = 32'(t * 4 + int'($urandom_range(0, 3)));
      end
      if (n.op == OP_BAD) n.imm = 32'($urandom_range(0, 4));
      prog[i] = n;
      rom[i]  = enc(n);
    end
  endtask

  initial begin
    vec_t tbl [10];
    logic [31:0] fpc;
    int          steps;

    // reset and sequencing trace with NOPs only: drive rst, then sample after one edge
    tbl = '{'{1'b1, 32'h00, 1'b0}, '{1'b1, 32'h00, 1'b0}, '{1'b0, 32'h00, 1'b0},
            '{1'b0, 32'h04, 1'b0}, '{1'b0, 32'h04, 1'b0}, '{1'b0, 32'h08, 1'b0},
            '{1'b0, 32'h08, 1'b0}, '{1'b1, 32'h00, 1'b0}, '{1'b0, 32'h00, 1'b0},
            '{1'b0, 32'h04, 1'b0}};
    clear_rom();
    last_pc = 32'd100;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst;
      @(negedge clk);
      chk($sformatf("trace%0d_instr_addr", i), instr_addr, tbl[i].addr);
      chk($sformatf("trace%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].we));
    end

    // ADDI x1,x0,5 ; SW x1,8(x0): store visible in cycle 4
    clear_rom();
    put(0, OP_ADDI, 1, 0, 0, 32'd5);
    put(1, OP_SW, 0, 0, 1, 32'd8);
    start(32'd100);
    repeat (3) @(negedge clk);
    chk("sw_cycle4_we", 32'(mem_we), 32'd1);
    chk("sw_cycle4_addr", mem_addr, 32'h8);
    chk("sw_cycle4_data", mem_data, 32'h5);
    // reset during the store's EXEC cycle must mask the strobe immediately
    rst = 1'b1;
    #1 chk("sw_rst_gate_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("sw_rst_pc", instr_addr, 32'h0);

    // LUI/ADDI composition and negative immediate
    clear_rom();
    put(0, OP_LUI, 2, 0, 0, 32'h12345000);
    put(1, OP_ADDI, 2, 2, 0, 32'h678);
    put(2, OP_SW, 0, 0, 2, 32'd0);
    put(3, OP_ADDI, 3, 0, 0, 32'hFFFF_FFFF);
    put(4, OP_SW, 0, 0, 3, 32'd4);
    expect_store(32'h0, 32'h12345678);
    expect_store(32'h4, 32'hFFFF_FFFF);
    start(32'd4);
    finish_run("lui", 14, 32'h14);

    // countdown loop then fall-through
    clear_rom();
    put(0, OP_ADDI, 1, 0, 0, 32'd3);
    put(1, OP_ADDI, 1, 1, 0, 32'hFFFF_FFFF);
    put(2, OP_SW, 0, 0, 1, 32'd0);
    put(3, OP_BNE, 0, 1, 0, 32'hFFFF_FFF8);
    put(4, OP_ADDI, 5, 0, 0, 32'd9);
    put(5, OP_SW, 0, 0, 5, 32'd12);
    expect_store(32'h0, 32'd2);
    expect_store(32'h0, 32'd1);
    expect_store(32'h0, 32'd0);
    expect_store(32'hC, 32'd9);
    start(32'd5);
    finish_run("loop", 30, 32'h18);

    // x0 stays zero; JAL at 0x10 links 0x14 and skips word 5
    clear_rom();
    put(0, OP_ADDI, 0, 0, 0, 32'd7);
    put(1, OP_SW, 0, 0, 0, 32'd4);
    put(4, OP_JAL, 1, 0, 0, 32'd8);
    put(5, OP_ADDI, 2, 0, 0, 32'd1);
    put(6, OP_SW, 0, 0, 1, 32'd0);
    put(7, OP_SW, 0, 0, 2, 32'd4);
    expect_store(32'h4, 32'd0);
    expect_store(32'h0, 32'h14);
    expect_store(32'h4, 32'd0);
    start(32'd7);
    repeat (10) @(negedge clk);
    chk("jal_next_fetch", instr_addr, 32'h18);
    finish_run("jal", 8, 32'h20);

    // halt point: only the word-2 store executes; restart after reset
    clear_rom();
    put(0, OP_ADDI, 1, 0, 0, 32'h55);
    put(2, OP_SW, 0, 0, 1, 32'h20);
    put(3, OP_SW, 0, 0, 1, 32'h24);
    expect_store(32'h20, 32'h55);
    start(32'd2);
    finish_run("halt", 20, 32'h0C);
    repeat (10) @(negedge clk);
    chk("halt_hold_pc", instr_addr, 32'h0C);
    chk("halt_hold_stores", 32'(act_addr.size()), 32'd1);
    start(32'd2);
    chk("restart_fetch_pc", instr_addr, 32'h0);
    finish_run("restart", 12, 32'h0C);

    // random forward-flowing programs against the reference model
    for (int p = 0; p < 30; p++) begin
      gen_prog(24);
      run_model(32'd23, fpc, steps);
      start(32'd23);
      finish_run($sformatf("rnd%0d", p), 2 * steps + 6, fpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
